hex_scroll_ctrl: RTL and testbench
==================================

Name: hex_scroll_ctrl

Overview:
Sequencer that drives the 3-bit character decoders on the HEX displays. It holds a 5-slot character buffer, loaded one code at a time from SW. On a programmable tick it rotates the buffer, so the word scrolls across HEX4..HEX0. Output slot k feeds the decoder for HEXk; the decoders stay purely combinational and are instantiated outside this block.

Parameters:
TICK_DIV, 50000000, clock cycles per rotation step; legal range 1..2^CNT_W.
CNT_W, 26, width of the tick prescaler counter.

Ports:
CLOCK_50  input  1   system clock; all state changes on its rising edge.
resetn    input  1   asynchronous, active-low reset.
SW        input  3   character code written on load.
load      input  1   single-cycle pulse; writes SW into slot wr_ptr (IDLE only).
run       input  1   level; 1 = scroll, 0 = hold.
step      input  1   single-cycle pulse; one rotation while paused.
clr       input  1   synchronous clear; returns the block to IDLE.
chars     output 15  slot k = chars[3k+2:3k], k = 0..4, to decoder k.
tick      output 1   one-cycle pulse on each rotation.
state     output 2   00 IDLE, 01 RUN, 10 PAUSE.

Behaviour:
- Reset (resetn=0, asynchronous) and clr=1 (synchronous) have the same effect:
  - every slot = 3'b111 (blank code)
  - wr_ptr = 0, prescaler cnt = 0
  - tick = 0, state = IDLE
- clr has priority over every other input, in every state.
- Rotation, in a single cycle: new slot[k] = old slot[(k+1) mod 5]. Slot 0 receives the old slot 1; slot 4 receives the old slot 0.
- tick is registered and is high in the cycle after the rotating edge. chars updates on that same edge.
- IDLE:
  - load=1: slot[wr_ptr] <= SW; wr_ptr increments 0..4, then wraps to 0 (the 6th load overwrites slot 0).
  - run=1: go to RUN, cnt <= 0. If load is also high in that cycle, the write happens first.
  - step is ignored. No rotation occurs in IDLE.
- RUN:
  - cnt counts 0..TICK_DIV-1.
  - At cnt = TICK_DIV-1: rotate, set tick, cnt <= 0.
  - With TICK_DIV=1 it rotates every cycle.
  - run=0: go to PAUSE; cnt holds its value. If the rotation edge coincides with run=0, the rotation still occurs, then the block enters PAUSE.
  - load and step are ignored.
- PAUSE:
  - cnt is frozen.
  - step=1: rotate and set tick.
  - run=1: go to RUN and resume from the frozen cnt. If step and run are both high, the step rotation occurs and the transition also occurs.
  - load is ignored; the buffer can only be rewritten after clr.
- Reset or clr during RUN or PAUSE aborts immediately; no partial rotation occurs.
- wr_ptr is not affected by rotation.
- The state encoding 11 is unreachable; if it is ever entered, the next edge goes to IDLE.

Test Plan:
- Reset check: drive resetn=0 mid-count → chars=15'h7FFF, tick=0, state=00 immediately, without waiting for a clock edge.
- Load sequence: load codes 0,1,2,3,4 → chars = {3'd4,3'd3,3'd2,3'd1,3'd0} (=15'o43210). A 6th load of code 5 → slot 0 = 5, other slots unchanged.
- Scroll timing (TICK_DIV=4): load 0..4, set run=1.
  - tick pulses every 4 cycles.
  - After tick 1: chars = 15'o04321.
  - After tick 5: back to 15'o43210.
- Pause and step (TICK_DIV=4): run=0 at cnt=2 → no rotation for 20 cycles. step pulse → one rotation and one tick. run=1 → next tick exactly 2 cycles later, from the frozen cnt.
- Coincidences:
  - run falls on the rotating cycle → rotation occurs, state = PAUSE.
  - clr together with step in PAUSE → slots blank, state = IDLE, no tick.
  - load together with run in IDLE → code stored, then RUN.
- TICK_DIV=1: in RUN, tick is high every cycle and the buffer rotates every cycle (period 5 returns to the original).

Source files
------------

// File: rtl/hex_scroll_ctrl.sv
// Purpose: 5-slot character buffer for the HEX decoders, loaded from SW and rotated on a prescaled tick.
// Latency: load/rotation visible on chars one cycle after the sampling edge; tick is a registered pulse in that same cycle.
// Backpressure: none; load/step pulses that arrive in a state that ignores them are dropped, clr always wins.
module hex_scroll_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 26
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   input  logic [2:0]    SW,
   input  logic          load,
   input  logic          run,
   input  logic          step,
   input  logic          clr,
   output logic [14:0]   chars,
   output logic          tick,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   // Terminal prescaler value; TICK_DIV = 2^CNT_W maps onto all-ones.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [2:0]       BLANK    = 3'b111;

   state_t            cur_st;
   state_t            nxt_st;

   // Slot k lives in slots[k]; the packed layout is exactly the chars bus.
   logic [4:0][2:0]   slots;
   logic [4:0][2:0]   slots_nxt;
   logic [2:0]        wr_ptr;
   logic [2:0]        wr_ptr_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              rotate;
   logic              do_write;

   // State register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cur_st <= ST_IDLE;
      end else begin
         cur_st <= nxt_st;
      end
   end

   // Next-state logic plus the per-state rotate/write/count decisions; clr overrides everything.
   always_comb begin
      nxt_st   = cur_st;
      rotate   = 1'b0;
      do_write = 1'b0;
      cnt_nxt  = cnt;
      case (cur_st)
         ST_IDLE: begin
            do_write = load;
            if (run) begin
               nxt_st  = ST_RUN;
               cnt_nxt = '0;
            end
         end
         ST_RUN: begin
            // A rotation that is due still happens on the edge run drops.
            if (cnt == CNT_LAST) begin
               rotate  = 1'b1;
               cnt_nxt = '0;
            end else if (run) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
            if (!run) begin
               nxt_st = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            // cnt stays frozen so RUN resumes mid-period.
            rotate = step;
            if (run) begin
               nxt_st = ST_RUN;
            end
         end
         default: begin
            nxt_st = ST_IDLE;
         end
      endcase
      if (clr) begin
         nxt_st   = ST_IDLE;
         rotate   = 1'b0;
         do_write = 1'b0;
         cnt_nxt  = '0;
      end
   end

   // Buffer and write-pointer next values: rotation and writes are mutually exclusive by state.
   always_comb begin
      slots_nxt  = slots;
      wr_ptr_nxt = wr_ptr;
      if (clr) begin
         slots_nxt  = {5{BLANK}};
         wr_ptr_nxt = '0;
      end else if (rotate) begin
         // new slot[k] = old slot[k+1]; slot 4 takes the old slot 0.
         slots_nxt = {slots[0], slots[4:1]};
      end else if (do_write) begin
         for (int k = 0; k < 5; k++) begin
            if (wr_ptr == 3'(k)) begin
               slots_nxt[k] = SW;
            end
         end
         wr_ptr_nxt = (wr_ptr == 3'd4) ? 3'd0 : wr_ptr + 3'd1;
      end
   end

   // Datapath registers; tick marks the cycle in which the rotated buffer first appears.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         slots  <= {5{BLANK}};
         wr_ptr <= '0;
         cnt    <= '0;
         tick   <= 1'b0;
      end else begin
         slots  <= slots_nxt;
         wr_ptr <= wr_ptr_nxt;
         cnt    <= cnt_nxt;
         tick   <= rotate;
      end
   end

   assign chars = slots;
   assign state = cur_st;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: two instances (TICK_DIV=4 at the counter-width limit, and TICK_DIV=1)
// share all inputs; every cycle both are compared against a slot-array reference model.
// Directed table, hand-written corner sequences, then randomized traffic.
module tb_hex_scroll_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [2:0]  sw;
   logic        load, run, step, clr;
   logic [14:0] chars4, chars1;
   logic        tick4, tick1;
   logic [1:0]  state4, state1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hex_scroll_ctrl #(.TICK_DIV(4), .CNT_W(2)) u_dut4 (
      .CLOCK_50(clk), .resetn(resetn), .SW(sw), .load(load), .run(run),
      .step(step), .clr(clr), .chars(chars4), .tick(tick4), .state(state4)
   );

   hex_scroll_ctrl #(.TICK_DIV(1), .CNT_W(1)) u_dut1 (
      .CLOCK_50(clk), .resetn(resetn), .SW(sw), .load(load), .run(run),
      .step(step), .clr(clr), .chars(chars1), .tick(tick1), .state(state1)
   );

   // ---------------- reference model ----------------
   // Index 0 models u_dut4, index 1 models u_dut1.
   // m_left = cycles still to go in the current scroll period; m_st: 0 idle, 1 run, 2 pause.
   logic [2:0] m_slot [2][5];
   int         m_ptr  [2];
   int         m_left [2];
   int         m_st   [2];
   bit         m_tick [2];

   function automatic int div_of(int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic model_reset(int i);
      for (int k = 0; k < 5; k++) m_slot[i][k] = 3'b111;
      m_ptr[i]  = 0;
      m_left[i] = div_of(i);
      m_st[i]   = 0;
      m_tick[i] = 1'b0;
   endtask

   task automatic model_step(int i, bit ld, bit rn, bit stp, bit cl, logic [2:0] s);
      bit         rot;
      logic [2:0] first;
      rot = 1'b0;
      if (cl) begin
         model_reset(i);
      end else begin
         case (m_st[i])
            0: begin
               if (ld) begin
                  m_slot[i][m_ptr[i]] = s;
                  m_ptr[i] = (m_ptr[i] + 1) % 5;
               end
               if (rn) begin
                  m_st[i]   = 1;
                  m_left[i] = div_of(i);
               end
            end
            1: begin
               if (m_left[i] == 1) begin
                  rot       = 1'b1;
                  m_left[i] = div_of(i);
               end else if (rn) begin
                  m_left[i] = m_left[i] - 1;
               end
               if (!rn) m_st[i] = 2;
            end
            default: begin
               rot = stp;
               if (rn) m_st[i] = 1;
            end
         endcase
         if (rot) begin
            first = m_slot[i][0];
            for (int k = 0; k < 4; k++) m_slot[i][k] = m_slot[i][k+1];
            m_slot[i][4] = first;
         end
         m_tick[i] = rot;
      end
   endtask

   function automatic logic [14:0] m_chars(int i);
      logic [14:0] v;
      for (int k = 0; k < 5; k++) v[3*k +: 3] = m_slot[i][k];
      return v;
   endfunction

   function automatic logic [14:0] rot15(logic [14:0] x);
      return {x[2:0], x[14:3]};
   endfunction

   // ---------------- checking ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("dut4 chars", 32'(chars4), 32'(m_chars(0)));
      chk("dut4 tick",  32'(tick4),  32'(m_tick[0]));
      chk("dut4 state", 32'(state4), 32'(m_st[0]));
      chk("dut1 chars", 32'(chars1), 32'(m_chars(1)));
      chk("dut1 tick",  32'(tick1),  32'(m_tick[1]));
      chk("dut1 state", 32'(state1), 32'(m_st[1]));
   endtask

   // Drive one cycle of inputs, step the model on the edge, compare 1 time unit later.
   task automatic apply(bit ld, bit rn, bit stp, bit cl, logic [2:0] s);
      load = ld; run = rn; step = stp; clr = cl; sw = s;
      @(posedge clk);
      model_step(0, ld, rn, stp, cl, s);
      model_step(1, ld, rn, stp, cl, s);
      #1;
      compare_all();
   endtask

   // ---------------- directed table (expectations for u_dut4) ----------------
   typedef struct {
      bit          ld, rn, stp, cl;
      logic [2:0]  s;
      logic [14:0] e_chars;
      bit          e_tick;
      logic [1:0]  e_state;
   } vec_t;

   vec_t tbl [$];

   task automatic add(bit ld, bit rn, bit stp, bit cl, logic [2:0] s,
                      logic [14:0] ec, bit et, logic [1:0] es);
      vec_t v;
      v.ld = ld; v.rn = rn; v.stp = stp; v.cl = cl; v.s = s;
      v.e_chars = ec; v.e_tick = et; v.e_state = es;
      tbl.push_back(v);
   endtask

   initial begin
      logic [14:0] rot_seq [6];
      logic [14:0] held;
      int          tcnt;
      bit          r;

      rot_seq[0] = 15'o43210; rot_seq[1] = 15'o04321; rot_seq[2] = 15'o10432;
      rot_seq[3] = 15'o21043; rot_seq[4] = 15'o32104; rot_seq[5] = 15'o43210;

      add(0,0,0,1, 3'd0, 15'o77777, 0, 2'b00);
      add(1,0,0,0, 3'd0, 15'o77770, 0, 2'b00);
      add(1,0,0,0, 3'd1, 15'o77710, 0, 2'b00);
      add(1,0,0,0, 3'd2, 15'o77210, 0, 2'b00);
      add(1,0,0,0, 3'd3, 15'o73210, 0, 2'b00);
      add(1,0,0,0, 3'd4, 15'o43210, 0, 2'b00);
      add(1,0,0,0, 3'd5, 15'o43215, 0, 2'b00);   // 6th load wraps onto slot 0
      add(0,0,1,1, 3'd0, 15'o77777, 0, 2'b00);
      for (int k = 0; k < 5; k++) add(1,0,1,0, 3'(k), 15'o77777, 0, 2'b00);
      // Row above only carries inputs; its expected chars are fixed up below.
      tbl[8].e_chars  = 15'o77770; tbl[9].e_chars  = 15'o77710;
      tbl[10].e_chars = 15'o77210; tbl[11].e_chars = 15'o73210;
      tbl[12].e_chars = 15'o43210;
      add(0,1,0,0, 3'd0, 15'o43210, 0, 2'b01);
      for (int i = 0; i < 20; i++)
         add(0,1,0,0, 3'd0, rot_seq[(i+1)/4], (i % 4) == 3, 2'b01);
      add(0,0,0,0, 3'd0, 15'o43210, 0, 2'b10);

      // Reset values, observed without any clock edge.
      resetn = 1'b1; load = 0; run = 0; step = 0; clr = 0; sw = 3'd0;
      #1 resetn = 1'b0;
      #1;
      chk("reset chars4", 32'(chars4), 32'h7FFF);
      chk("reset tick4",  32'(tick4),  32'd0);
      chk("reset state4", 32'(state4), 32'd0);
      chk("reset chars1", 32'(chars1), 32'h7FFF);
      model_reset(0);
      model_reset(1);
      #10 resetn = 1'b1;

      foreach (tbl[i]) begin
         apply(tbl[i].ld, tbl[i].rn, tbl[i].stp, tbl[i].cl, tbl[i].s);
         chk($sformatf("tbl[%0d] chars", i), 32'(chars4), 32'(tbl[i].e_chars));
         chk($sformatf("tbl[%0d] tick",  i), 32'(tick4),  32'(tbl[i].e_tick));
         chk($sformatf("tbl[%0d] state", i), 32'(state4), 32'(tbl[i].e_state));
      end

      // Pause at cnt=2, hold, single step, resume from the frozen count.
      apply(0,1,0,0,3'd0);
      apply(0,1,0,0,3'd0);
      apply(0,1,0,0,3'd0);
      apply(0,0,0,0,3'd0);
      chk("pause entered", 32'(state4), 32'b10);
      held = chars4;
      tcnt = 0;
      for (int i = 0; i < 20; i++) begin
         apply(0,0,0,0,3'd0);
         if (tick4) tcnt++;
      end
      chk("pause ticks", 32'(tcnt), 32'd0);
      chk("pause chars held", 32'(chars4), 32'(held));
      apply(0,0,1,0,3'd0);
      chk("step tick", 32'(tick4), 32'd1);
      chk("step chars", 32'(chars4), 32'(rot15(held)));
      apply(0,0,0,0,3'd0);
      chk("step tick single", 32'(tick4), 32'd0);
      apply(0,1,0,0,3'd0);
      chk("resume e0 tick", 32'(tick4), 32'd0);
      apply(0,1,0,0,3'd0);
      chk("resume e1 tick", 32'(tick4), 32'd0);
      apply(0,1,0,0,3'd0);
      chk("resume e2 tick", 32'(tick4), 32'd1);

      // run drops on the rotating edge.
      apply(0,1,0,0,3'd0);
      apply(0,1,0,0,3'd0);
      apply(0,1,0,0,3'd0);
      held = chars4;
      apply(0,0,0,0,3'd0);
      chk("runfall tick", 32'(tick4), 32'd1);
      chk("runfall state", 32'(state4), 32'b10);
      chk("runfall chars", 32'(chars4), 32'(rot15(held)));

      // clr together with step in PAUSE.
      apply(0,0,1,1,3'd0);
      chk("clr+step chars", 32'(chars4), 32'h7FFF);
      chk("clr+step tick", 32'(tick4), 32'd0);
      chk("clr+step state", 32'(state4), 32'b00);

      // load together with run in IDLE.
      apply(1,1,0,0,3'd6);
      chk("load+run chars", 32'(chars4), 32'(15'o77776));
      chk("load+run state", 32'(state4), 32'b01);

      // Asynchronous reset in the middle of a count.
      apply(0,1,0,0,3'd0);
      #2 resetn = 1'b0;
      #1;
      chk("async chars4", 32'(chars4), 32'h7FFF);
      chk("async tick4",  32'(tick4),  32'd0);
      chk("async state4", 32'(state4), 32'd0);
      chk("async state1", 32'(state1), 32'd0);
      model_reset(0);
      model_reset(1);
      #2 resetn = 1'b1;

      // TICK_DIV=1: rotates every RUN cycle, period 5.
      for (int k = 0; k < 5; k++) apply(1,0,0,0,3'(k));
      apply(0,1,0,0,3'd0);
      tcnt = 0;
      for (int i = 0; i < 10; i++) begin
         apply(0,1,0,0,3'd0);
         if (tick1) tcnt++;
         if (i == 0) chk("div1 first rot", 32'(chars1), 32'(15'o04321));
         if (i == 4) chk("div1 period", 32'(chars1), 32'(15'o43210));
      end
      chk("div1 ticks", 32'(tcnt), 32'd10);

      // Randomized traffic against the model.
      apply(0,0,0,1,3'd0);
      r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) r = ~r;
         apply($urandom_range(0, 3) == 0, r, $urandom_range(0, 3) == 0,
               $urandom_range(0, 59) == 0, 3'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
